spi_master: RTL
===============

# spi_master

SPI mode-0 master that drives the `ss`/`sclk`/`mosi` lines of the team's `spi_slave` and captures its `miso` response. It sits between the on-chip register/control logic and the serial pins. The master generates `sclk` from the system clock, shifts out one `DATA_WIDTH`-bit word per transaction, and returns the word captured in parallel. A start/busy/done handshake controls each transaction.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: bits per transaction. Must be at least 2.
- `CLK_DIV`, default 4: length of each `sclk` half-period in `clk` cycles. Must be at least 2.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a transaction. Sampled only while `busy`=0.
- `tx_data`, input, `DATA_WIDTH`: word to transmit. Latched on the edge that accepts `start`.
- `busy`, output, 1: high from acceptance through the end of the inter-frame gap.
- `done`, output, 1: one-cycle pulse when `rx_data` is valid.
- `rx_data`, output, `DATA_WIDTH`: last received word. Holds its value until the next `done`.
- `ss`, output, 1: slave select, active-low.
- `sclk`, output, 1: serial clock. Idles low (CPOL=0).
- `mosi`, output, 1: serial data out.
- `miso`, input, 1: serial data in. Driven by a slave on the same `clk`, so no synchronizer is used.

## Operation
- State machine: IDLE → SETUP → SHIFT_HI ↔ SHIFT_LO → GAP → IDLE.
- **IDLE:** `ss`=1, `sclk`=0, `busy`=0. If `start`=1 at an edge, then at that edge:
  - load `tx_data` into the TX shift register;
  - set `ss`=0, `busy`=1;
  - drive `mosi` with the first bit;
  - go to SETUP.
- **SETUP:** wait `CLK_DIV` cycles with `sclk`=0, then set `sclk`=1 and go to SHIFT_HI.
- **SHIFT_HI:** after `CLK_DIV` cycles, at a single edge:
  - shift `miso` into the RX shift register;
  - set `sclk`=0;
  - if bits remain, present the next bit on `mosi` and go to SHIFT_LO;
  - otherwise set `mosi`=0 and go to GAP.
- **SHIFT_LO:** after `CLK_DIV` cycles, set `sclk`=1 and go to SHIFT_HI.
- **GAP:**
  - On its first edge (`CLK_DIV` cycles after the last falling edge): `ss`=1, `rx_data` ← RX shift register, `done`=1 for one cycle.
  - `CLK_DIV` cycles after that: `busy`=0, go to IDLE.
- Bit counter: counts `DATA_WIDTH` down to 0, width $clog2(`DATA_WIDTH`+1). The half-period counter is $clog2(`CLK_DIV`) bits wide.
- `start` asserted while `busy`=1 is ignored. It is not queued.
- `tx_data` changes after acceptance have no effect on the current frame.
- `start` held high continuously: a new frame is accepted on the first edge where `busy`=0.
- Reset (`reset_n`=0), at any time including mid-frame, takes effect immediately without waiting for a clock edge:
  - `ss`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0;
  - state returns to IDLE;
  - the partial frame is discarded.

## Timing
- Let E0 be the edge that accepts `start`.
- E0: `ss` falls, `busy` rises, `mosi` = first bit.
- Rising edge k of `sclk` (k = 0..`DATA_WIDTH`-1) occurs at E0 + (2k+1)·`CLK_DIV`.
- Falling edge k occurs at E0 + (2k+2)·`CLK_DIV`. At that edge `miso` is sampled and `mosi` advances.
- `mosi` is stable for `CLK_DIV` cycles on each side of every rising `sclk` edge.
- `ss` rises and `done` pulses at E0 + (2·`DATA_WIDTH`+1)·`CLK_DIV`.
- `busy` falls at E0 + (2·`DATA_WIDTH`+2)·`CLK_DIV`.
- Defaults: `sclk` rises at E0+4; `done` at E0+68; `busy` low at E0+72; next acceptance possible at E0+72.

## Configuration
- Macro: `SPI_MASTER_LSB_FIRST_EN`.
- Defined: bit 0 of `tx_data` is sent first, and received bits fill `rx_data` from bit 0 upward.
- Undefined (default): MSB first. The first received bit lands in `rx_data[DATA_WIDTH-1]`.
- Timing is identical in both modes.

## Test plan
- **Loopback byte:** tie `miso`=`mosi`, pulse `start` with `tx_data`=8'hA5 → `done` at E0+68, `rx_data`=8'hA5, exactly 8 `sclk` rising edges, `ss` low for 68 cycles.
- **Fixed slave pattern:** model drives `miso` bits 1,0,1,1,0,0,1,0 on successive falling edges (first bit valid before rising edge 0), `tx_data`=8'h3C → `rx_data`=8'hB2, `mosi` sequence 0,0,1,1,1,1,0,0.
- **Start while busy:** second `start` pulse with `tx_data`=8'hFF at E0+20 → ignored. Only one `done`, `mosi` carries the first word only.
- **Back-to-back:** `start` held high with 8'h01 then 8'h80 → second frame accepted at E0+72, `ss` high for 4 cycles between frames, two `done` pulses 72 cycles apart.
- **Reset mid-frame:** `reset_n` low at E0+30 (between clock edges) → `ss`=1, `sclk`=0, `busy`=0 immediately. After release, a new 8'h5A loopback frame completes correctly.
- **Macro build:** with `SPI_MASTER_LSB_FIRST_EN` defined, `tx_data`=8'h01 → first `mosi` bit is 1. Loopback `rx_data`=8'h01.

Source files
------------

// File: rtl/spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_master
//  Purpose  : SPI mode-0 (CPOL=0, CPHA=0) master. It generates sclk from clk,
//             shifts out one DATA_WIDTH-bit word per transaction and returns
//             the word captured from miso. Each transaction is controlled by
//             a start/busy/done handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_WIDTH : bits per transaction (>= 2)
//    CLK_DIV    : sclk half-period in clk cycles (>= 2)
//  Ports
//    clk      in   system clock, rising edge
//    reset_n  in   asynchronous active-low reset
//    start    in   transaction request, sampled when the master can accept
//    tx_data  in   word to send, latched on the accepting edge
//    busy     out  high from acceptance to the end of the inter-frame gap
//    done     out  one-cycle pulse when rx_data is updated
//    rx_data  out  last received word, held until the next done
//    ss       out  slave select, active low
//    sclk     out  serial clock, idles low
//    mosi     out  serial data out
//    miso     in   serial data in (slave runs on clk, no synchronizer)
//  Configuration
//    SPI_MASTER_LSB_FIRST_EN : defined -> LSB first; undefined -> MSB first
// ============================================================================
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  ss,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int c_cnt_w  = $clog2(CLK_DIV);
  localparam int c_bits_w = $clog2(DATA_WIDTH + 1);

  localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(CLK_DIV - 1);
  localparam logic [c_bits_w-1:0] c_bits_one  = c_bits_w'(1);
  localparam logic [c_bits_w-1:0] c_bits_init = c_bits_w'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_SHIFT_HI = 3'd2,
    S_SHIFT_LO = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  state_t                r_state, w_state;
  logic [c_cnt_w-1:0]    r_cnt, w_cnt;
  logic [c_bits_w-1:0]   r_bits, w_bits;
  logic [DATA_WIDTH-1:0] r_tx, w_tx;
  logic [DATA_WIDTH-1:0] r_rx, w_rx;
  logic [DATA_WIDTH-1:0] r_rx_data, w_rx_data;
  logic                  r_ss, w_ss;
  logic                  r_sclk, w_sclk;
  logic                  r_mosi, w_mosi;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic                  w_load;
  logic                  w_half_end;

  // Bit-order dependent views of the shift registers. The TX register is
  // rotated rather than shifted; only the bit at the output end is ever
  // presented, so the wrapped-around bits are never seen on mosi.
  logic                  w_first_bit;
  logic [DATA_WIDTH-1:0] w_tx_rot;
  logic [DATA_WIDTH-1:0] w_rx_shift;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign w_first_bit = tx_data[0];
  assign w_tx_rot    = {r_tx[0], r_tx[DATA_WIDTH-1:1]};
  assign w_rx_shift  = {miso, r_rx[DATA_WIDTH-1:1]};
`else
  assign w_first_bit = tx_data[DATA_WIDTH-1];
  assign w_tx_rot    = {r_tx[DATA_WIDTH-2:0], r_tx[DATA_WIDTH-1]};
  assign w_rx_shift  = {r_rx[DATA_WIDTH-2:0], miso};
`endif

  // Next bit to present after a falling edge is the new output-end bit.
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic w_next_bit;
  assign w_next_bit = w_tx_rot[0];
`else
  logic w_next_bit;
  assign w_next_bit = w_tx_rot[DATA_WIDTH-1];
`endif

  assign w_half_end = (r_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bits    <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_ss      <= 1'b1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_bits    <= w_bits;
      r_tx      <= w_tx;
      r_rx      <= w_rx;
      r_rx_data <= w_rx_data;
      r_ss      <= w_ss;
      r_sclk    <= w_sclk;
      r_mosi    <= w_mosi;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt + c_cnt_one;
    w_bits    = r_bits;
    w_tx      = r_tx;
    w_rx      = r_rx;
    w_rx_data = r_rx_data;
    w_ss      = r_ss;
    w_sclk    = r_sclk;
    w_mosi    = r_mosi;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_load    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_cnt  = '0;
        w_load = start;
      end
      S_SETUP, S_SHIFT_LO: begin
        if (w_half_end) begin
          w_cnt   = '0;
          w_sclk  = 1'b1;
          w_state = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (w_half_end) begin
          w_cnt  = '0;
          w_sclk = 1'b0;
          w_rx   = w_rx_shift;
          w_bits = r_bits - c_bits_one;
          if (r_bits > c_bits_one) begin
            w_tx    = w_tx_rot;
            w_mosi  = w_next_bit;
            w_state = S_SHIFT_LO;
          end else begin
            w_mosi  = 1'b0;
            w_state = S_GAP;
          end
        end
      end
      S_GAP: begin
        // Two half-periods: ss still low marks the first one, which ends the
        // frame; the second one is the inter-frame gap. A held start is
        // accepted directly at the end of the gap so back-to-back frames
        // leave ss high for exactly one half-period.
        if (w_half_end) begin
          w_cnt = '0;
          if (!r_ss) begin
            w_ss      = 1'b1;
            w_rx_data = r_rx;
            w_done    = 1'b1;
          end else if (start) begin
            w_load = 1'b1;
          end else begin
            w_busy  = 1'b0;
            w_state = S_IDLE;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    if (w_load) begin
      w_state = S_SETUP;
      w_cnt   = '0;
      w_bits  = c_bits_init;
      w_tx    = tx_data;
      w_rx    = '0;
      w_ss    = 1'b0;
      w_sclk  = 1'b0;
      w_busy  = 1'b1;
      w_mosi  = w_first_bit;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign ss      = r_ss;
  assign sclk    = r_sclk;
  assign mosi    = r_mosi;

endmodule
`default_nettype wire
